// File: rtl/adc_xy_align.sv
// Aligns x/y samples with a separately delayed color stream using a sample-indexed
// history; outputs are registered and only pulse once the history covers both delays.
module adc_xy_align #(
  parameter int DATA_BITS  = 10,
  parameter int COLOR_BITS = 3,
  parameter int MAX_DELAY  = 7,
  localparam int DELAY_BITS = $clog2(MAX_DELAY + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic [DATA_BITS-1:0]  in_x,
  input  logic [DATA_BITS-1:0]  in_y,
  input  logic [COLOR_BITS-1:0] in_color,
  input  logic [DELAY_BITS-1:0] xy_delay,
  input  logic [DELAY_BITS-1:0] color_delay,
  output logic                  out_valid,
  output logic [DATA_BITS-1:0]  out_x,
  output logic [DATA_BITS-1:0]  out_y,
  output logic [COLOR_BITS-1:0] out_color,
  output logic                  primed
);
  localparam int N_BITS = $clog2(MAX_DELAY + 2);
  localparam logic [DELAY_BITS-1:0] MAXD  = DELAY_BITS'(MAX_DELAY);
  localparam logic [N_BITS-1:0]     N_SAT = N_BITS'(MAX_DELAY + 1);

  // hist_*[i] holds the sample accepted i+1 samples ago
  logic [MAX_DELAY-1:0][DATA_BITS-1:0]  hist_x, hist_y;
  logic [MAX_DELAY-1:0][COLOR_BITS-1:0] hist_c;
  // cand_*[k] is the sample k accepts back, with the current input at k=0
  logic [MAX_DELAY:0][DATA_BITS-1:0]    cand_x, cand_y;
  logic [MAX_DELAY:0][COLOR_BITS-1:0]   cand_c;

  logic [DELAY_BITS-1:0] xy_q, col_q, xy_k, col_k, d_max;
  logic [N_BITS-1:0]     n, n_nxt;
  logic                  loaded, chg, prime_nxt;

  always_comb begin
    cand_x[0] = in_x;
    cand_y[0] = in_y;
    cand_c[0] = in_color;
    for (int i = 0; i < MAX_DELAY; i++) begin
      cand_x[i+1] = hist_x[i];
      cand_y[i+1] = hist_y[i];
      cand_c[i+1] = hist_c[i];
    end
  end

  always_comb begin
    xy_k  = (xy_delay > MAXD) ? MAXD : xy_delay;
    col_k = (color_delay > MAXD) ? MAXD : color_delay;
    d_max = (xy_k > col_k) ? xy_k : col_k;
    // the first edge after reset only loads the copies
    chg   = loaded && ((xy_delay != xy_q) || (color_delay != col_q));
    n_nxt = n;
    if (chg)
      n_nxt = in_valid ? N_BITS'(1) : '0;
    else if (in_valid && (n != N_SAT))
      n_nxt = n + N_BITS'(1);
    prime_nxt = n_nxt > N_BITS'(d_max);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist_x    <= '0;
      hist_y    <= '0;
      hist_c    <= '0;
      xy_q      <= '0;
      col_q     <= '0;
      loaded    <= 1'b0;
      n         <= '0;
      primed    <= 1'b0;
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_color <= '0;
    end else begin
      loaded    <= 1'b1;
      xy_q      <= xy_delay;
      col_q     <= color_delay;
      n         <= n_nxt;
      primed    <= prime_nxt;
      out_valid <= in_valid && prime_nxt;
      if (in_valid) begin
        hist_x[0] <= in_x;
        hist_y[0] <= in_y;
        hist_c[0] <= in_color;
        for (int i = 1; i < MAX_DELAY; i++) begin
          hist_x[i] <= hist_x[i-1];
          hist_y[i] <= hist_y[i-1];
          hist_c[i] <= hist_c[i-1];
        end
      end
      if (in_valid && prime_nxt) begin
        out_x     <= cand_x[xy_k];
        out_y     <= cand_y[xy_k];
        out_color <= cand_c[col_k];
      end
    end
  end
endmodule

// File: tb/tb_adc_xy_align.sv
// Scoreboard bench: two instances (MAX_DELAY 7 and 5) driven with identical stimulus,
// each compared against a sample-list reference model.
module tb_adc_xy_align;
  logic clk = 1'b0;
  logic rst_n;
  logic in_valid;
  logic [9:0] in_x, in_y;
  logic [2:0] in_color, xy_delay, color_delay;
  logic [1:0] ov, pr;
  logic [1:0][9:0] ox, oy;
  logic [1:0][2:0] oc;

  always #5 clk = ~clk;

  adc_xy_align u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .xy_delay(xy_delay), .color_delay(color_delay),
    .out_valid(ov[0]), .out_x(ox[0]), .out_y(oy[0]), .out_color(oc[0]), .primed(pr[0]));

  adc_xy_align #(.MAX_DELAY(5)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .in_color(in_color), .xy_delay(xy_delay), .color_delay(color_delay),
    .out_valid(ov[1]), .out_x(ox[1]), .out_y(oy[1]), .out_color(oc[1]), .primed(pr[1]));

  typedef struct { logic [9:0] x; logic [9:0] y; logic [2:0] c; } smp_t;
  typedef struct { bit v; bit p; smp_t o; } cyc_t;

  smp_t dq0[$], dq1[$];
  cyc_t cq0[$], cq1[$];
  int errors = 0;
  int checks = 0;

  // reference model state: every sample accepted since reset, in order
  logic [9:0] sx[2][4096], sy[2][4096];
  logic [2:0] sc[2][4096];
  int cnt[2], ntr[2], xyq[2], cdq[2];
  bit loaded[2];
  smp_t last[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int m, output bit v_o, output bit p_o, output smp_t o);
    int maxd, dx, dc, d;
    maxd = (m == 0) ? 7 : 5;
    if (!rst_n) begin
      cnt[m] = 0; ntr[m] = 0; loaded[m] = 0; xyq[m] = 0; cdq[m] = 0;
      last[m] = '{x: 0, y: 0, c: 0};
      v_o = 0; p_o = 0; o = last[m];
      return;
    end
    if (loaded[m] && (int'(xy_delay) != xyq[m] || int'(color_delay) != cdq[m])) ntr[m] = 0;
    loaded[m] = 1;
    xyq[m] = int'(xy_delay);
    cdq[m] = int'(color_delay);
    if (in_valid) begin
      sx[m][cnt[m]] = in_x; sy[m][cnt[m]] = in_y; sc[m][cnt[m]] = in_color;
      cnt[m]++;
      ntr[m]++;
    end
    dx = (int'(xy_delay) > maxd) ? maxd : int'(xy_delay);
    dc = (int'(color_delay) > maxd) ? maxd : int'(color_delay);
    d  = (dx > dc) ? dx : dc;
    p_o = ntr[m] > d;
    v_o = in_valid && p_o;
    if (v_o) begin
      last[m].x = sx[m][cnt[m]-1-dx];
      last[m].y = sy[m][cnt[m]-1-dx];
      last[m].c = sc[m][cnt[m]-1-dc];
    end
    o = last[m];
  endtask

  task automatic predict();
    bit v, p;
    smp_t o;
    for (int m = 0; m < 2; m++) begin
      step(m, v, p, o);
      if (m == 0) begin
        cq0.push_back('{v: v, p: p, o: o});
        if (v) dq0.push_back(o);
      end else begin
        cq1.push_back('{v: v, p: p, o: o});
        if (v) dq1.push_back(o);
      end
    end
  endtask

  task automatic cyc(input bit v, input int x, input int c, input int xy, input int cd);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = v;
    in_x = 10'(x);
    in_y = 10'(x * 3 + 7);
    in_color = 3'(c);
    xy_delay = 3'(xy);
    color_delay = 3'(cd);
    predict();
  endtask

  task automatic do_reset(input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      rst_n = 1'b0;
      in_valid = 1'b0;
      predict();
      #1;
      for (int m = 0; m < 2; m++) begin
        chk("rst_out_valid", ov[m], 0);
        chk("rst_primed", pr[m], 0);
        chk("rst_out_x", ox[m], 0);
        chk("rst_out_color", oc[m], 0);
      end
    end
  endtask

  // monitor: one per-cycle status record per edge, data popped only on out_valid
  initial begin
    cyc_t r;
    smp_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int m = 0; m < 2; m++) begin
        if ((m == 0 && cq0.size() == 0) || (m == 1 && cq1.size() == 0)) begin
          chk("status_queue_empty", 1, 0);
        end else begin
          r = (m == 0) ? cq0.pop_front() : cq1.pop_front();
          chk("out_valid", ov[m], int'(r.v));
          chk("primed", pr[m], int'(r.p));
          if (ov[m]) begin
            if ((m == 0 && dq0.size() == 0) || (m == 1 && dq1.size() == 0)) begin
              chk("unexpected_pulse", 1, 0);
            end else begin
              e = (m == 0) ? dq0.pop_front() : dq1.pop_front();
              chk("out_x", ox[m], e.x);
              chk("out_y", oy[m], e.y);
              chk("out_color", oc[m], e.c);
            end
          end else begin
            chk("hold_x", ox[m], r.o.x);
            chk("hold_y", oy[m], r.o.y);
            chk("hold_color", oc[m], r.o.c);
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = '0; in_y = '0; in_color = '0;
    xy_delay = '0; color_delay = '0;
    predict();
    #1;
    chk("init_out_valid", ov[0], 0);
    chk("init_primed", pr[0], 0);
    chk("init_out_x", ox[0], 0);
    @(negedge clk);
    predict();

    // zero delays, every cycle valid
    for (int i = 1; i <= 4; i++) cyc(1, i, i, 0, 0);
    cyc(0, 0, 0, 0, 0);
    // color lagging by two samples
    do_reset(1);
    for (int i = 1; i <= 5; i++) cyc(1, i + 2, i, 0, 2);
    // gapped input, delay 1 on x/y
    do_reset(1);
    cyc(1, 10, 1, 1, 1); cyc(0, 0, 0, 1, 1); cyc(0, 0, 0, 1, 1);
    cyc(1, 20, 2, 1, 1); cyc(0, 0, 0, 1, 1); cyc(1, 30, 3, 1, 1);
    cyc(0, 0, 0, 1, 1);
    // delay change on a valid edge after priming
    for (int i = 0; i < 5; i++) cyc(1, 40 + i, i, 0, 1);
    for (int i = 0; i < 6; i++) cyc(1, 50 + i, i + 1, 0, 3);
    // delay change on an idle edge
    cyc(0, 0, 0, 2, 3);
    for (int i = 0; i < 5; i++) cyc(1, 60 + i, i, 2, 3);
    // delay 7 clamps to 5 on the smaller instance
    do_reset(1);
    for (int i = 1; i <= 9; i++) cyc(1, 100 + i, i, 0, 7);
    // mid-stream reset while primed, then delay 2
    do_reset(1);
    for (int i = 1; i <= 5; i++) cyc(1, 200 + i, i, 2, 0);

    // randomized traffic with occasional delay changes and resets
    begin
      int xy, cd;
      xy = 1; cd = 2;
      for (int i = 0; i < 1500; i++) begin
        if ($urandom_range(299) == 0) do_reset($urandom_range(1, 2));
        if ($urandom_range(29) == 0) begin
          xy = $urandom_range(7);
          cd = $urandom_range(7);
        end
        cyc($urandom_range(9) < 7, $urandom_range(1023), $urandom_range(7), xy, cd);
      end
    end

    @(posedge clk);
    #2;
    chk("pending_pulses_0", dq0.size(), 0);
    chk("pending_pulses_1", dq1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
